// File: rtl/ttpu_pkg.sv
// Shared types and helpers for the convolution accumulator: FSM states,
// address/kernel width helpers and the saturation classifier.
package ttpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH
    } state_e;

    typedef enum logic [1:0] {
        SAT_NONE,
        SAT_POS,
        SAT_NEG
    } sat_e;

    // Widest accumulator the classifier accepts; callers sign-extend into it.
    localparam int SAT_W = 128;

    function automatic int addr_w(input int w, input int h);
        return $clog2(w * h);
    endfunction

    function automatic int kdim_w(input int w);
        return $clog2(w);
    endfunction

    // Tells the caller whether v lies above, below or inside the signed dw-bit range.
    function automatic sat_e sat_class(input logic signed [SAT_W-1:0] v, input int dw);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
        lo = ~hi;
        if (v > hi) return SAT_POS;
        if (v < lo) return SAT_NEG;
        return SAT_NONE;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One lane: registered product (S1), running accumulator (S2) and
// saturated result register (S3).
module mac_lane
    import ttpu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 38
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         clr_i,
    input  logic                         beat_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    input  logic                         s1_vld_i,
    input  logic                         s1_first_i,
    input  logic                         s2_last_i,
    output logic        [DATA_WIDTH-1:0] data_o
);

    logic signed [2*DATA_WIDTH-1:0] prod_q, prod_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d, prod_ext;
    logic        [DATA_WIDTH-1:0]   data_q, data_d;
    sat_e                           sat;

    assign prod_d   = beat_i ? ((2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i)) : prod_q;
    assign prod_ext = ACC_WIDTH'(prod_q);
    assign sat      = sat_class(SAT_W'(acc_q), DATA_WIDTH);

    // The first tap of a window loads the product directly, so windows abut with no bubble.
    always_comb begin
        acc_d = acc_q;
        if (clr_i)         acc_d = '0;
        else if (s1_vld_i) acc_d = s1_first_i ? prod_ext : acc_q + prod_ext;
    end

    always_comb begin
        data_d = data_q;
        if (s2_last_i) begin
            case (sat)
                SAT_POS: data_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
                SAT_NEG: data_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
                default: data_d = acc_q[DATA_WIDTH-1:0];
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prod_q <= '0;
            acc_q  <= '0;
            data_q <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/conv_accumulator.sv
// Multiply-accumulate over k*k kernel windows across NUM_UNITS lanes, writing
// one saturated NUM_UNITS-wide beat per window to scratch memory.
module conv_accumulator
    import ttpu_pkg::*;
#(
    parameter  int DATA_WIDTH   = 16,
    parameter  int IMAGE_WIDTH  = 8,
    parameter  int IMAGE_HEIGHT = 8,
    parameter  int NUM_UNITS    = 2,
    parameter  int ACC_WIDTH    = 2*DATA_WIDTH + 2*$clog2(IMAGE_WIDTH),
    localparam int ADDR_W       = addr_w(IMAGE_WIDTH, IMAGE_HEIGHT),
    localparam int KW           = kdim_w(IMAGE_WIDTH)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  start_i,
    input  logic [KW-1:0]                         kernel_dim_i,
    input  logic [ADDR_W-1:0]                     num_windows_i,
    input  logic [ADDR_W-1:0]                     base_addr_i,
    input  logic                                  en_in_1_i,
    input  logic                                  en_in_2_i,
    input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  in_1_i,
    input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  in_2_i,
    output logic                                  wr_en_o,
    output logic [NUM_UNITS-1:0][ADDR_W-1:0]      wr_addr_o,
    output logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  wr_data_o,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  err_o
);

    state_e               state_q;
    logic [2*KW-1:0]      taps_q, tap_cnt_q;
    logic [ADDR_W-1:0]    nwin_q, base_q, win_cnt_q;
    logic                 busy_q, done_q, err_q;

    logic                 s1_vld_q, s1_first_q, s1_last_q, s2_last_q, wr_en_q;
    logic [ADDR_W-1:0]    s1_win_q, s2_win_q;
    logic [NUM_UNITS-1:0][ADDR_W-1:0] wr_addr_q, wr_addr_d;

    logic beat, tap_last, win_last, start_ok;

    assign beat     = (state_q == ACCUM) && en_in_1_i && en_in_2_i;
    assign tap_last = (tap_cnt_q == taps_q - (2*KW)'(1));
    assign win_last = (win_cnt_q == nwin_q - ADDR_W'(1));
    assign start_ok = (state_q == IDLE) && start_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            taps_q    <= '0;
            tap_cnt_q <= '0;
            nwin_q    <= '0;
            base_q    <= '0;
            win_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        taps_q    <= (2*KW)'(kernel_dim_i) * (2*KW)'(kernel_dim_i);
                        nwin_q    <= num_windows_i;
                        base_q    <= base_addr_i;
                        tap_cnt_q <= '0;
                        win_cnt_q <= '0;
                        err_q     <= (kernel_dim_i == '0);
                        if (kernel_dim_i == '0 || num_windows_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (en_in_1_i ^ en_in_2_i) err_q <= 1'b1;
                    if (beat) begin
                        if (tap_last) begin
                            tap_cnt_q <= '0;
                            win_cnt_q <= win_cnt_q + ADDR_W'(1);
                            if (win_last) state_q <= FLUSH;
                        end else begin
                            tap_cnt_q <= tap_cnt_q + (2*KW)'(1);
                        end
                    end
                end
                FLUSH: begin
                    // Earlier windows may still be writing; finish on the last write only.
                    if (wr_en_q && !s2_last_q && !s1_vld_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        wr_addr_d = '0;
        for (int i = 0; i < NUM_UNITS; i++)
            wr_addr_d[i] = base_q + s2_win_q * ADDR_W'(NUM_UNITS) + ADDR_W'(i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_win_q   <= '0;
            s2_last_q  <= 1'b0;
            s2_win_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            s1_vld_q   <= beat;
            s1_first_q <= (tap_cnt_q == '0);
            s1_last_q  <= tap_last;
            s1_win_q   <= win_cnt_q;
            s2_last_q  <= s1_vld_q && s1_last_q;
            s2_win_q   <= s1_win_q;
            wr_en_q    <= s2_last_q;
            if (s2_last_q) wr_addr_q <= wr_addr_d;
        end
    end

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_lane
        mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .clr_i      (start_ok),
            .beat_i     (beat),
            .a_i        (in_1_i[i]),
            .b_i        (in_2_i[i]),
            .s1_vld_i   (s1_vld_q),
            .s1_first_i (s1_first_q),
            .s2_last_i  (s2_last_q),
            .data_o     (wr_data_o[i])
        );
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule

// File: doc/conv_accumulator.md
# conv_accumulator

Downstream stage of the dual memory units in `top_memory`. It consumes the per-lane operand streams `out_1`/`out_2`, qualified by `en_out_1`/`en_out_2`, and multiplies each lane's pair. Products are accumulated over one k×k kernel window, then each lane result is saturated to DATA_WIDTH. Results are written as one NUM_UNITS-wide beat per window into the simple scratch-memory write port (`simple_write_addr`/`simple_write_data`/`simple_write`).

## Interface
Parameters:
- DATA_WIDTH, 16, operand and result width (signed two's complement)
- IMAGE_WIDTH, 8, image width; sets kernel_dim width
- IMAGE_HEIGHT, 8, image height; with IMAGE_WIDTH sets address space
- NUM_UNITS, 2, parallel lanes
- ACC_WIDTH, 2*DATA_WIDTH+2*$clog2(IMAGE_WIDTH), signed accumulator width; no overflow possible for k ≤ IMAGE_WIDTH-1

Ports (ADDR_W = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT), KW = $clog2(IMAGE_WIDTH)):
- clk  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle job launch pulse
- kernel_dim  in  KW  k; window has k*k taps
- num_windows  in  ADDR_W  windows in the job
- base_addr  in  NUM_UNITS*ADDR_W... single ADDR_W  first write address
- en_in_1  in  1  operand-1 beat valid
- en_in_2  in  1  operand-2 beat valid
- in_1  in  NUM_UNITS×DATA_WIDTH  operand-1 lanes
- in_2  in  NUM_UNITS×DATA_WIDTH  operand-2 lanes
- wr_en  out  1  write strobe
- wr_addr  out  NUM_UNITS×ADDR_W  per-lane write address
- wr_data  out  NUM_UNITS×DATA_WIDTH  per-lane saturated result
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- err  out  1  sticky error flag

## Operation
- FSM states:
  - IDLE
    - `start` latches k, taps = k*k (width 2*KW), num_windows, base_addr.
    - Clears the tap counter, window counter, accumulators and err, then goes to ACCUM.
    - If k==0: set err, stay IDLE, and pulse done next cycle.
    - If num_windows==0: pulse done next cycle, stay IDLE, no writes.
  - ACCUM
    - A beat is counted only when en_in_1 && en_in_2.
    - If exactly one of en_in_1/en_in_2 is high: set err (sticky) and discard that beat.
    - On the beat where tap_cnt == taps-1, the lane sums are final.
    - That beat's product closes the window. The accumulator reloads 0 without a bubble, so the next window's first beat may arrive on the very next cycle.
    - On the final beat of the last window, go to FLUSH.
  - FLUSH: wait for the pipeline to drain, then pulse done and return to IDLE.
- Arithmetic:
  - Product: signed DATA_WIDTH × DATA_WIDTH gives 2*DATA_WIDTH, sign-extended to ACC_WIDTH.
  - Saturation: clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Addressing:
  - wr_addr[i] = base_addr + win_cnt*NUM_UNITS + i, modulo 2^ADDR_W, so the address wraps silently.
- `start` while busy is ignored. Operand beats seen in IDLE are ignored and do not set err.
- reset low mid-job aborts immediately. No partial write is emitted after release.

## Timing
- Pipeline stages:
  - S1: register the product.
  - S2: accumulate.
  - S3: register wr_data/wr_addr/wr_en.
- Latency: a window's final beat at cycle t produces wr_en=1 at cycle t+3, held for exactly one cycle.
- done pulses in the cycle after the last wr_en.
- busy:
  - Rises the cycle after an accepted start.
  - Falls in the same cycle done is asserted.
- Back-to-back 1-tap windows (k=1) are sustained at one write per cycle.
- Reset values: wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, err 0; FSM in IDLE; all counters and accumulators 0.

## Structure
- Shared package `ttpu_pkg`:
  - FSM state enum (IDLE, ACCUM, FLUSH)
  - saturating-narrow function
  - ADDR_W/KW localparam helpers
- Sub-module `mac_lane`: one lane's multiply register, accumulator and saturation, instantiated NUM_UNITS times.
- The top level holds the FSM, counters and address generation.

## Test plan
- k=2, num_windows=1, base_addr=10, 4 beats of lane0 (3,4), lane1 (-2,5) → one wr_en at last beat+3; wr_data = {lane0 48, lane1 -40}; wr_addr = {10, 11}; done the next cycle.
- Saturation: k=1, in_1=in_2=0x7FFF on both lanes → wr_data = 0x7FFF. Then in_1=0x8000, in_2=0x7FFF → wr_data = 0x8000.
- Continuous stream:
  - k=1, num_windows=4, base_addr=62 → 4 writes on consecutive cycles.
  - Addresses {62,63}, {0,1}, {2,3}, {4,5}, showing wrap-around.
- Gaps and mismatch:
  - k=2 with idle cycles inserted between beats → result unchanged.
  - A single en_in_1-only cycle → err=1 and the beat is not counted.
  - err stays high until the next start.
- Reset low for 1 cycle mid-window → all outputs return to 0. Next start with k=2 yields a fresh, correct result.
- Degenerate cases:
  - start with k=0 → err=1 and done pulse, no wr_en.
  - num_windows=0 → done, no wr_en, err=0.
  - start while busy → ignored.
